// File: rtl/result_serializer.sv
// Parallel-to-serial adapter: captures six result words in one handshake and streams them out
// one beat at a time with index and last flag. Define RESULT_SERIALIZER_CHECKSUM_EN for an XOR beat.
module result_serializer #(
    parameter int unsigned BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] s1,
    input  logic [BW-1:0] s2,
    input  logic [BW-1:0] s3,
    input  logic [BW-1:0] s4,
    input  logic [BW-1:0] s5,
    input  logic [BW-1:0] s6,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic [7:0]    frame_cnt
);

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    localparam int unsigned Last = 6;
`else
    localparam int unsigned Last = 5;
`endif
    localparam int unsigned NumBeats = Last + 1;
    localparam logic [2:0]  LastIdx  = 3'(Last);

    typedef enum logic {StIdle, StSend} state_e;

    state_e        state_q;
    logic [BW-1:0] buf_q [NumBeats];
    logic [2:0]    idx_q;
    logic [2:0]    idx_nxt;
    logic [BW-1:0] out_data_q;
    logic          out_last_q;
    logic [7:0]    frame_cnt_q;

    assign idx_nxt = idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < int'(NumBeats); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        buf_q[0]   <= s1;
                        buf_q[1]   <= s2;
                        buf_q[2]   <= s3;
                        buf_q[3]   <= s4;
                        buf_q[4]   <= s5;
                        buf_q[5]   <= s6;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                        buf_q[6]   <= s1 ^ s2 ^ s3 ^ s4 ^ s5 ^ s6;
`endif
                        // First beat is presented straight from the capture edge.
                        out_data_q <= s1;
                        idx_q      <= '0;
                        out_last_q <= 1'b0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        if (idx_q == LastIdx) begin
                            out_last_q  <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            state_q     <= StIdle;
                        end else begin
                            idx_q      <= idx_nxt;
                            out_data_q <= buf_q[idx_nxt];
                            out_last_q <= (idx_nxt == LastIdx);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StSend);
    assign busy      = (state_q == StSend);
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;

endmodule
